// File: rtl/fios_pkg.sv
// Shared types and sizing helpers for the FIOS Montgomery result path.
package fios_pkg;

  localparam int WORD_WIDTH = 17;

  // Number of 17-bit words needed to hold a result below 2p.
  function automatic int num_words(input int width);
    return (width + 1 + 16) / 17;
  endfunction

  typedef enum logic [1:0] {
    COL_IDLE    = 2'd0,
    COL_COLLECT = 2'd1,
    COL_SUB     = 2'd2,
    COL_HOLD    = 2'd3
  } fios_col_state_t;

endpackage

// File: rtl/fios_word_sub.sv
// One 17-bit word of a multi-word subtraction: diff = a - b - borrow_in.
module fios_word_sub
  import fios_pkg::*;
(
  input  logic [WORD_WIDTH-1:0] a_i,
  input  logic [WORD_WIDTH-1:0] b_i,
  input  logic                  borrow_i,
  output logic [WORD_WIDTH-1:0] diff_o,
  output logic                  borrow_o
);

  logic [WORD_WIDTH:0] full;

  assign full     = {1'b0, a_i} - {1'b0, b_i} - (WORD_WIDTH+1)'(borrow_i);
  assign diff_o   = full[WORD_WIDTH-1:0];
  assign borrow_o = full[WORD_WIDTH];

endmodule

// File: rtl/fios_res_collector.sv
// Collects result words from the FIOS chain, optionally subtracts p once, and hands
// the product downstream. Define FIOS_RES_FINAL_SUB_EN to enable the final subtraction.
module fios_res_collector
  import fios_pkg::*;
#(
  parameter  int WIDTH = 256,
  localparam int S     = num_words(WIDTH),
  localparam int RW    = S * WORD_WIDTH
) (
  input  logic                  clock_i,
  input  logic                  reset_n_i,
  input  logic                  start_i,
  input  logic                  res_valid_i,
  input  logic [WORD_WIDTH-1:0] res_i,
  input  logic [RW-1:0]         p_i,
  output logic [RW-1:0]         result_o,
  output logic                  result_valid_o,
  input  logic                  result_ready_i,
  output logic                  busy_o,
  output logic                  err_o
);

  localparam int              CNT_W = $clog2(S + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(S - 1);

  fios_col_state_t  state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [RW-1:0]    words_q, words_d;
  logic [RW-1:0]    result_q, result_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;

  logic handshake, start_acc, word_acc, last_word;

  assign handshake = valid_q & result_ready_i;
  // A start in HOLD only counts when it coincides with the handshake.
  assign start_acc = start_i & ((state_q != COL_HOLD) | handshake);
  assign word_acc  = res_valid_i & ~start_i & (state_q == COL_COLLECT);
  assign last_word = word_acc & (cnt_q == LAST);

`ifdef FIOS_RES_FINAL_SUB_EN
  logic [RW-1:0]         diff_q, diff_d;
  logic                  borrow_q, borrow_d;
  logic [WORD_WIDTH-1:0] sub_diff;
  logic                  sub_borrow;

  fios_word_sub u_word_sub (
    .a_i      (words_q[cnt_q*WORD_WIDTH +: WORD_WIDTH]),
    .b_i      (p_i[cnt_q*WORD_WIDTH +: WORD_WIDTH]),
    .borrow_i (borrow_q),
    .diff_o   (sub_diff),
    .borrow_o (sub_borrow)
  );
`else
  logic unused_p;
  assign unused_p = ^p_i;
`endif

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) state_q <= COL_IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (start_acc) begin
      state_d = COL_COLLECT;
    end else begin
      case (state_q)
        COL_COLLECT: begin
`ifdef FIOS_RES_FINAL_SUB_EN
          if (last_word) state_d = COL_SUB;
`else
          if (last_word) state_d = COL_HOLD;
`endif
        end
        COL_SUB:  if (cnt_q == LAST) state_d = COL_HOLD;
        COL_HOLD: if (handshake) state_d = COL_IDLE;
        default:  state_d = state_q;
      endcase
    end
  end

  always_comb begin
    busy_d = (state_d == COL_COLLECT) || (state_d == COL_SUB);
`ifdef FIOS_RES_FINAL_SUB_EN
    valid_d = (state_d == COL_HOLD);
`else
    // Raw results still spend one registered cycle in HOLD before being offered.
    valid_d = (state_q == COL_HOLD) && !handshake;
`endif
    if (start_acc)                                   err_d = 1'b0;
    else if (res_valid_i && state_q != COL_COLLECT) err_d = 1'b1;
    else                                             err_d = err_q;
  end

  always_comb begin
    cnt_d    = cnt_q;
    words_d  = words_q;
    result_d = result_q;
`ifdef FIOS_RES_FINAL_SUB_EN
    diff_d   = diff_q;
    borrow_d = borrow_q;
`endif
    if (start_acc) begin
      cnt_d = '0;
    end else if (word_acc) begin
      words_d[cnt_q*WORD_WIDTH +: WORD_WIDTH] = res_i;
      cnt_d = last_word ? '0 : cnt_q + CNT_W'(1);
`ifdef FIOS_RES_FINAL_SUB_EN
      if (last_word) borrow_d = 1'b0;
`else
      if (last_word) result_d = words_d;
`endif
    end
`ifdef FIOS_RES_FINAL_SUB_EN
    else if (state_q == COL_SUB) begin
      diff_d[cnt_q*WORD_WIDTH +: WORD_WIDTH] = sub_diff;
      borrow_d = sub_borrow;
      cnt_d    = cnt_q + CNT_W'(1);
      // Final borrow set means word < p, so the raw value is already reduced.
      if (cnt_q == LAST) begin
        result_d = sub_borrow ? words_q : diff_d;
        cnt_d    = '0;
      end
    end
`endif
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cnt_q    <= '0;
      words_q  <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
`ifdef FIOS_RES_FINAL_SUB_EN
      diff_q   <= '0;
      borrow_q <= 1'b0;
`endif
    end else begin
      cnt_q    <= cnt_d;
      words_q  <= words_d;
      result_q <= result_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
`ifdef FIOS_RES_FINAL_SUB_EN
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
`endif
    end
  end

  assign result_o       = result_q;
  assign result_valid_o = valid_q;
  assign busy_o         = busy_q;
  assign err_o          = err_q;

endmodule

// File: tb/tb_fios_res_collector.sv
// Directed bench for fios_res_collector, WIDTH=32 (S=2), p=0xFFFFFFFB.
module tb_fios_res_collector;

  localparam int WIDTH = 32;
  localparam int RW    = 34;

`ifdef FIOS_RES_FINAL_SUB_EN
  localparam int          LAT    = 2;
  localparam logic [33:0] EXP_P5 = 34'd5;
  localparam logic [33:0] EXP_P  = 34'd0;
`else
  localparam int          LAT    = 1;
  localparam logic [33:0] EXP_P5 = 34'h100000000;
  localparam logic [33:0] EXP_P  = 34'h0FFFFFFFB;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          res_valid = 1'b0;
  logic [16:0]   res = '0;
  logic [RW-1:0] p = 34'h0FFFFFFFB;
  logic [RW-1:0] result;
  logic          result_valid;
  logic          ready = 1'b0;
  logic          busy;
  logic          err;

  int total = 0;
  int bad   = 0;

  fios_res_collector #(.WIDTH(WIDTH)) dut (
    .clock_i        (clk),
    .reset_n_i      (rst_n),
    .start_i        (start),
    .res_valid_i    (res_valid),
    .res_i          (res),
    .p_i            (p),
    .result_o       (result),
    .result_valid_o (result_valid),
    .result_ready_i (ready),
    .busy_o         (busy),
    .err_o          (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s got=%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic run_job(input string tag, input logic [16:0] w0, input logic [16:0] w1,
                         input logic [33:0] exp);
    int lat;
    res_valid = 1'b1;
    res = w0;
    tick();
    res = w1;
    tick();
    res_valid = 1'b0;
    res = '0;
    lat = 0;
    while (!result_valid && lat < 20) begin
      tick();
      lat++;
    end
    check({tag, "_lat"}, 64'(lat), 64'(LAT));
    check({tag, "_res"}, 64'(result), 64'(exp));
  endtask

  task automatic accept(input string tag);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    check({tag, "_valid_drop"}, 64'(result_valid), 64'd0);
    check({tag, "_idle"}, 64'(busy), 64'd0);
  endtask

  logic [33:0] held;

  initial begin
    tick();
    tick();
    check("rst_result", 64'(result), 64'd0);
    check("rst_valid", 64'(result_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    rst_n = 1'b1;
    tick();

    pulse_start();
    check("p5_busy", 64'(busy), 64'd1);
    run_job("p5", 17'h00000, 17'h08000, EXP_P5);
    check("p5_busy_hold", 64'(busy), 64'd0);
    accept("p5");

    pulse_start();
    run_job("w7", 17'h00007, 17'h00000, 34'd7);
    accept("w7");

    pulse_start();
    run_job("eqp", 17'h1FFFB, 17'h07FFF, EXP_P);
    held = result;
    repeat (10) tick();
    check("hold_stable", 64'(result), 64'(held));
    check("hold_valid", 64'(result_valid), 64'd1);
    start = 1'b1;
    ready = 1'b1;
    tick();
    start = 1'b0;
    ready = 1'b0;
    check("restart_busy", 64'(busy), 64'd1);
    check("restart_valid", 64'(result_valid), 64'd0);
    run_job("after", 17'h00007, 17'h00000, 34'd7);
    accept("after");

    res_valid = 1'b1;
    res = 17'h00005;
    tick();
    res_valid = 1'b0;
    check("err_set", 64'(err), 64'd1);
    tick();
    tick();
    check("err_sticky", 64'(err), 64'd1);
    pulse_start();
    check("err_clear", 64'(err), 64'd0);
    res_valid = 1'b1;
    res = 17'h01234;
    tick();
    start = 1'b1;
    res = 17'h1ABCD;
    tick();
    start = 1'b0;
    res_valid = 1'b0;
    check("abort_err", 64'(err), 64'd0);
    check("abort_busy", 64'(busy), 64'd1);
    run_job("abort", 17'h00000, 17'h08000, EXP_P5);

    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 64'(result_valid), 64'd0);
    check("arst_result", 64'(result), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    rst_n = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
